des_key_schedule: RTL
=====================

Name: des_key_schedule

Overview:
- Iterative DES key-schedule generator that sits directly upstream of the round stage.
- Takes a 64-bit DES key and produces the 48-bit round subkeys K1..K16, one per handshake, in encrypt order or reverse (decrypt) order.
- Output is valid/ready handshaked so a pipelined or iterative round chain can stall it.
- Internally it holds the 28-bit C and D halves, applies PC-1 at load, rotates by the DES shift schedule, and drives the output through PC-2.

Parameters:
- NUM_ROUNDS, 16: number of subkeys emitted per start. Legal range 1..16; values below 16 truncate the sequence after K(NUM_ROUNDS) in the current order.

Ports:
- i_clk  input  1  system clock
- i_rst_n  input  1  asynchronous, active-low reset
- i_key  input  64  DES key. i_key[63] is DES bit 1; parity bits (DES bits 8,16,..,64) are ignored.
- i_decrypt  input  1  0 = emit K1..K16; 1 = emit K16..K1. Sampled only when a start is accepted.
- i_start  input  1  start request; honoured only in IDLE
- i_ready  input  1  downstream can accept o_subkey this cycle
- o_subkey  output  48  current subkey, PC-2 of the registered C/D; o_subkey[47] is PC-2 bit 1
- o_subkey_dv  output  1  o_subkey valid
- o_round_idx  output  4  0-based index of the subkey being presented (count of handshakes so far)
- o_busy  output  1  high in VALID
- o_done  output  1  one-cycle pulse after the final subkey handshake

Behaviour:
- Reset (async assert, synchronous deassert handled externally): state=IDLE; C, D, mode, index, o_subkey_dv, o_round_idx, o_busy, o_done all 0. o_subkey is 0 because it is PC-2 of C/D=0.
- Reset asserted mid-sequence aborts immediately; no o_done is produced.
- Shift schedule (encrypt, steps 0..15): 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1. All rotations are within each 28-bit half independently.
- Encrypt mode: step j rotates C/D left by sched[j].
- Decrypt mode: step 0 rotates by 0; step j≥1 rotates right by sched[16-j].
- States: IDLE and VALID.
- IDLE:
  - o_subkey_dv=0, o_busy=0.
  - If i_start: {C,D} <= rotate(PC1(i_key), step 0); mode <= i_decrypt; idx <= 0; go to VALID.
  - i_key is not used after this cycle.
- VALID:
  - o_subkey_dv=1, o_busy=1, o_round_idx=idx.
  - o_subkey is held stable while i_ready=0 (no change to C, D or idx).
  - On handshake (o_subkey_dv & i_ready):
    - if idx==NUM_ROUNDS-1: go to IDLE and set o_done=1 for the next cycle;
    - else {C,D} <= rotate({C,D}, step idx+1) and idx <= idx+1.
- Latency: start accepted at cycle N → K(first) valid at N+1. With i_ready held high, the last subkey is valid at N+NUM_ROUNDS, o_dv drops and o_done=1 at N+NUM_ROUNDS+1.
- i_start while VALID is ignored; it is neither queued nor allowed to restart.
- i_start in the same cycle as the o_done pulse (state is IDLE) is accepted normally, giving back-to-back keys with one idle cycle.
- o_done is registered and lasts exactly one cycle. o_done and o_subkey_dv are never high together.
- i_decrypt and i_key changes while VALID have no effect.

Test Plan:
- Encrypt, key 0x133457799BBCDFF1, i_ready=1 → o_subkey 0x1B02EFFC7072 (idx 0) at N+1, 0x79AED9DBC9E5 (idx 1) at N+2, 0xCB3D8B0E17F5 (idx 15) at N+16, o_done at N+17.
- Decrypt, same key → first subkey 0xCB3D8B0E17F5 (idx 0), last 0x1B02EFFC7072 (idx 15). The full sequence equals the encrypt sequence reversed.
- Backpressure: toggle i_ready randomly → the 16 subkeys received equal the no-stall sequence. o_subkey and o_round_idx are stable on every cycle with dv=1 and ready=0.
- Start while busy (pulse i_start at idx 5 with a different key) → sequence unaffected. Then start in the o_done cycle → new sequence begins on the next cycle.
- Reset mid-run (i_rst_n low at idx 7) → outputs 0 immediately and no o_done. A new start after release produces the correct K1.
- NUM_ROUNDS=4 → only K1..K4 are emitted and o_done follows K4's handshake. Decrypt mode emits K16..K13.

Source files
------------

// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: PC-1 at start, per-round C/D rotation, PC-2 on the
// registered halves. Emits NUM_ROUNDS subkeys over a valid/ready handshake.
module des_key_schedule #(
  parameter int unsigned NUM_ROUNDS = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [63:0] i_key,
  input  logic        i_decrypt,
  input  logic        i_start,
  input  logic        i_ready,
  output logic [47:0] o_subkey,
  output logic        o_subkey_dv,
  output logic [3:0]  o_round_idx,
  output logic        o_busy,
  output logic        o_done
);

  typedef enum logic {ST_IDLE, ST_VALID} state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS - 1);

  // Table entries are DES bit numbers (1 = MSB of the source vector).
  localparam int unsigned PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  function automatic logic [55:0] pc1(input logic [63:0] key);
    logic [55:0] r;
    r = '0;
    for (int unsigned i = 0; i < 56; i++) r[55-i] = key[6'(64 - PC1_TBL[i])];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int unsigned i = 0; i < 48; i++) r[47-i] = cd[6'(56 - PC2_TBL[i])];
    return r;
  endfunction

  function automatic logic [1:0] sched(input logic [3:0] step);
    return (step == 4'd0 || step == 4'd1 || step == 4'd8 || step == 4'd15) ? 2'd1 : 2'd2;
  endfunction

  // Decrypt walks the schedule backwards: step j undoes encrypt step 16-j.
  function automatic logic [1:0] step_amt(input logic [3:0] step, input logic dec);
    if (!dec)               return sched(step);
    else if (step == 4'd0)  return 2'd0;
    else                    return sched(4'(5'd16 - {1'b0, step}));
  endfunction

  function automatic logic [27:0] rot28(input logic [27:0] x, input logic [1:0] amt,
                                        input logic left);
    case (amt)
      2'd1:    return left ? {x[26:0], x[27]}    : {x[0], x[27:1]};
      2'd2:    return left ? {x[25:0], x[27:26]} : {x[1:0], x[27:2]};
      default: return x;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic        mode_q, mode_d;
  logic [3:0]  idx_q, idx_d;
  logic        done_q, done_d;
  logic [55:0] cd_init;
  logic [1:0]  amt;
  logic [3:0]  nxt_idx;

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    cd_init = pc1(i_key);
    nxt_idx = idx_q + 4'd1;
    amt     = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          amt     = step_amt(4'd0, i_decrypt);
          c_d     = rot28(cd_init[55:28], amt, ~i_decrypt);
          d_d     = rot28(cd_init[27:0], amt, ~i_decrypt);
          mode_d  = i_decrypt;
          idx_d   = '0;
          state_d = ST_VALID;
        end
      end
      ST_VALID: begin
        if (i_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            idx_d   = '0;
          end else begin
            amt   = step_amt(nxt_idx, mode_q);
            c_d   = rot28(c_q, amt, ~mode_q);
            d_d   = rot28(d_q, amt, ~mode_q);
            idx_d = nxt_idx;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      c_q     <= '0;
      d_q     <= '0;
      mode_q  <= 1'b0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // Key parity bits are dropped by PC-1.
  logic unused_parity;
  assign unused_parity = ^{i_key[56], i_key[48], i_key[40], i_key[32],
                           i_key[24], i_key[16], i_key[8],  i_key[0]};

  assign o_subkey    = pc2({c_q, d_q});
  assign o_subkey_dv = (state_q == ST_VALID);
  assign o_busy      = (state_q == ST_VALID);
  assign o_round_idx = idx_q;
  assign o_done      = done_q;

endmodule
